// File: rtl/mem_ctrler_pkg.sv
// mem_ctrler_pkg
//   Shared types and helpers for the memory controller that arbitrates the
//   instruction fetcher and the load/store unit onto the byte-wide RAM/IO bus.
//   Contents:
//     addr_t, byte_t       - bus address and data byte
//     mem_width_t          - LSU access width code (0=byte, 1=half, 2=word, 3=word)
//     state_t              - controller FSM states
//     width_to_bytes()     - width code -> byte count
//     is_io_addr()         - IO-space decode on the two bits ending at a mask bit
package mem_ctrler_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [7:0]  byte_t;
  typedef logic [1:0]  mem_width_t;

  localparam mem_width_t WIDTH_BYTE = 2'd0;
  localparam mem_width_t WIDTH_HALF = 2'd1;
  localparam mem_width_t WIDTH_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The illegal code 3 is served as a word access.
  function automatic logic [2:0] width_to_bytes(input mem_width_t w);
    case (w)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  // Address bits [mask_bit:mask_bit-1] both set select IO space.
  function automatic logic is_io_addr(input addr_t a, input int mask_bit);
    return ((a >> (mask_bit - 1)) & 32'd3) == 32'd3;
  endfunction

endpackage

// File: rtl/mem_ctrler.sv
// mem_ctrler
//   Responder for instruction-line fetches and LSU loads/stores, sharing one
//   byte-wide synchronous RAM/IO bus. Lines are assembled byte by byte; LSU
//   accesses are 1, 2 or 4 bytes, little-endian, no alignment requirement.
//
//   Handshake (both requester ports): the requester raises valid with a stable
//   address/command and holds it until it sees a one-cycle ready pulse; the
//   controller samples valid only in IDLE, and a DONE cycle always follows a
//   ready pulse so a requester that drops valid the cycle after ready is never
//   served twice. When both ports request in IDLE the LSU wins.
//
//   Ports:
//     clk, rst                    clock; synchronous active-low reset
//     rdy                         global enable; low freezes all registers
//     valid/addr_from_inst_fetcher, ready_to_inst_fetcher,
//     cache_line_to_inst_fetcher  line fetch port (byte k at bits [8k+7:8k])
//     valid/write/addr/width/data_from_lsu, ready_to_lsu,
//     data_to_lsu                 load/store port (loads zero-extended)
//     mem_din, mem_dout, mem_a,
//     mem_wr                      RAM/IO bus; mem_din valid one cycle after mem_a
//     io_buffer_full              IO output FIFO full; stalls IO stores
//     dbg_state                   current FSM state
module mem_ctrler
  import mem_ctrler_pkg::*;
#(
  parameter int LINE_BYTES  = 16,
  parameter int IO_MASK_BIT = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    valid_from_inst_fetcher,
  input  logic [31:0]             addr_from_inst_fetcher,
  output logic                    ready_to_inst_fetcher,
  output logic [8*LINE_BYTES-1:0] cache_line_to_inst_fetcher,
  input  logic                    valid_from_lsu,
  input  logic                    write_from_lsu,
  input  logic [31:0]             addr_from_lsu,
  input  logic [1:0]              width_from_lsu,
  input  logic [31:0]             data_from_lsu,
  output logic                    ready_to_lsu,
  output logic [31:0]             data_to_lsu,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  output state_t                  dbg_state
);

  localparam int OW = $clog2(LINE_BYTES);  // byte offset within a line
  localparam int CW = OW + 1;              // counter reaches LINE_BYTES+1
  localparam int LW = 8 * LINE_BYTES;
  localparam addr_t OFS_MASK = addr_t'(LINE_BYTES - 1);

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  addr_t                         req_addr_q, req_addr_d;
  logic [CW-1:0]                 req_n_q, req_n_d;
  logic [3:0][7:0]               wdata_q, wdata_d;
  logic [LINE_BYTES-1:0][7:0]    asm_q, asm_d;
  logic [LW-1:0]                 line_q, line_d;
  logic [31:0]                   data_q, data_d;
  addr_t                         mem_a_q, mem_a_d;
  byte_t                         mem_dout_q, mem_dout_d;
  logic                          mem_wr_q, mem_wr_d;
  logic                          rdy_if_q, rdy_if_d;
  logic                          rdy_lsu_q, rdy_lsu_d;

  logic [CW-1:0]                 step;
  logic [OW-1:0]                 cap_idx;
  addr_t                         byte_addr;

  // ------------------------------------------------------------------
  // Next-state and datapath
  //
  // Reads (IFETCH/DREAD): cnt counts edges since the accepting edge. At the
  // edge where cnt==c the address for byte c+1 is launched and the byte for
  // address c-1 (launched two edges earlier) is captured from mem_din. The
  // last capture happens when cnt==n, together with the ready pulse.
  //
  // Writes (DWRITE): cnt counts bytes already put on the bus. An IO store
  // with the FIFO full launches nothing and leaves cnt alone, so a stall
  // only adds latency. One idle edge (cnt==n) follows the last write, then
  // the ready pulse (cnt==n+1).
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_n_d    = req_n_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    line_d     = line_q;
    data_d     = data_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    rdy_if_d   = 1'b0;
    rdy_lsu_d  = 1'b0;
    step       = cnt_q + CW'(1);
    cap_idx    = OW'(cnt_q - CW'(1));
    byte_addr  = req_addr_q + 32'(cnt_q);

    case (state_q)
      IDLE: begin
        if (valid_from_lsu) begin
          req_addr_d = addr_from_lsu;
          req_n_d    = CW'(width_to_bytes(width_from_lsu));
          wdata_d    = data_from_lsu;
          asm_d      = '0;
          mem_a_d    = addr_from_lsu;
          cnt_d      = '0;
          if (write_from_lsu) begin
            state_d = DWRITE;
            // First byte goes out immediately unless the IO FIFO is full.
            if (!(is_io_addr(addr_from_lsu, IO_MASK_BIT) && io_buffer_full)) begin
              mem_dout_d = data_from_lsu[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = CW'(1);
            end
          end else begin
            state_d = DREAD;
          end
        end else if (valid_from_inst_fetcher) begin
          req_addr_d = addr_from_inst_fetcher & ~OFS_MASK;
          req_n_d    = CW'(LINE_BYTES);
          asm_d      = '0;
          mem_a_d    = addr_from_inst_fetcher & ~OFS_MASK;
          cnt_d      = '0;
          state_d    = IFETCH;
        end
      end

      IFETCH, DREAD: begin
        if (step < req_n_q) begin
          mem_a_d = req_addr_q + 32'(step);
        end
        if (cnt_q != '0) begin
          asm_d[cap_idx] = mem_din;
        end
        cnt_d = step;
        if (cnt_q == req_n_q) begin
          state_d = DONE;
          if (state_q == IFETCH) begin
            rdy_if_d = 1'b1;
            line_d   = asm_d;
          end else begin
            rdy_lsu_d = 1'b1;
            data_d    = asm_d[3:0];
          end
        end
      end

      DWRITE: begin
        if (cnt_q < req_n_q) begin
          if (!(is_io_addr(byte_addr, IO_MASK_BIT) && io_buffer_full)) begin
            mem_a_d    = byte_addr;
            mem_dout_d = wdata_q[cnt_q[1:0]];
            mem_wr_d   = 1'b1;
            cnt_d      = step;
          end
        end else if (cnt_q == req_n_q) begin
          cnt_d = step;
        end else begin
          rdy_lsu_d = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registers: reset wins over rdy; rdy low holds everything.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_n_q    <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      line_q     <= '0;
      data_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      rdy_if_q   <= 1'b0;
      rdy_lsu_q  <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_n_q    <= req_n_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      line_q     <= line_d;
      data_q     <= data_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      rdy_if_q   <= rdy_if_d;
      rdy_lsu_q  <= rdy_lsu_d;
    end
  end

  // A frozen write cycle must not repeat on the bus, so the strobe is gated
  // by rdy without waiting for a clock edge.
  assign mem_wr                     = mem_wr_q & rdy;
  assign mem_dout                   = mem_dout_q;
  assign mem_a                      = mem_a_q;
  assign ready_to_inst_fetcher      = rdy_if_q;
  assign cache_line_to_inst_fetcher = line_q;
  assign ready_to_lsu               = rdy_lsu_q;
  assign data_to_lsu                = data_q;
  assign dbg_state                  = state_q;

endmodule

// File: doc/mem_ctrler.md
Name: mem_ctrler

Overview:
Responder end of the instruction-fetch memory protocol. It also serves a data (load/store) port, and arbitrates both onto the single byte-wide synchronous RAM/IO bus. It assembles whole cache lines byte-by-byte for the instruction fetcher, and performs 1/2/4-byte reads and writes for the load/store unit. It sits between the core front-end/LSU and the top-level RAM/IO pins.

Parameters:
LINE_BYTES, 16, bytes per cache line; power of two; must match `CACHE_LINE_TYPE width / 8
IO_MASK_BIT, 17, address bits [17:16]==2'b11 mark IO space

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
rdy  in  1  global enable; low freezes all state
valid_from_inst_fetcher  in  1  line request, held high until ready seen
addr_from_inst_fetcher  in  32  request address, may be unaligned
ready_to_inst_fetcher  out  1  one-cycle pulse, line valid
cache_line_to_inst_fetcher  out  8*LINE_BYTES  byte k at bits [8k+7:8k]
valid_from_lsu  in  1  data request, held until ready seen
write_from_lsu  in  1  1=store, 0=load
addr_from_lsu  in  32  byte address
width_from_lsu  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
data_from_lsu  in  32  store data, little-endian
ready_to_lsu  out  1  one-cycle pulse
data_to_lsu  out  32  load data, zero-extended
mem_din  in  8  RAM/IO read byte, valid one cycle after mem_a
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1=write
io_buffer_full  in  1  IO output FIFO full

Behaviour:
- Reset (rst==0 at edge): state=IDLE, all outputs 0, byte counter 0. Reset mid-transaction aborts it; no ready pulse is issued.
- rdy==0: no state, counter or output register changes, except that mem_wr is forced to 0 combinationally.
- States: IDLE, IFETCH, DREAD, DWRITE, DONE.
- IDLE arbitration: when both valid inputs are high, LSU wins. The fetcher waits; its valid stays high.
- IFETCH
  - Base address = addr with low log2(LINE_BYTES) bits cleared.
  - At accepting edge E0: mem_a<=base, counter=0.
  - Cycles 1..LINE_BYTES drive base+0..base+LINE_BYTES-1 with mem_wr=0.
  - The byte for address k is captured from mem_din at edge E(k+2).
  - At edge E(LINE_BYTES+1) the last byte is captured, ready_to_inst_fetcher<=1, state->DONE.
- DREAD
  - Same pattern with n=1/2/4 bytes from addr (no alignment).
  - data_to_lsu updated at E(n+1) together with ready_to_lsu<=1; unused upper bytes are 0.
- DWRITE
  - Byte k (data_from_lsu[8k+7:8k]) is driven with mem_wr=1 at mem_a=addr+k for one cycle each; k=0..n-1 in cycles 1..n.
  - ready_to_lsu<=1 at E(n+1).
  - If the address is IO and io_buffer_full==1, the controller holds with mem_wr=0 and drives nothing until io_buffer_full==0. The stall adds latency and never drops bytes.
- DONE: ready pulses drop to 0; state->IDLE. No new request is accepted in DONE. This guarantees that a requester deasserting valid one cycle after ready is never re-served.
- Outside a write cycle mem_wr=0 and mem_dout=0. mem_a keeps its last value.
- cache_line_to_inst_fetcher and data_to_lsu hold their values until the next completion of the same port.
- Address arithmetic wraps mod 2^32.
- No flush input: an accepted transaction always completes.

Decomposition:
- config.v gains `MEM_WIDTH_TYPE [1:0]` and `IO_ADDR_RANGE`, and reuses `ADDR_TYPE`, `BYTE_TYPE` and `CACHE_LINE_TYPE`.
- No sub-module: one FSM with a shared byte counter.

Test Plan:
- Fetch addr 0x0000_1234, RAM[0x1230+k]=k -> mem_a walks 0x1230..0x123F. ready pulses exactly once, 17 cycles after the accepting edge. cache_line=0x0F0E..0100.
- Simultaneous LSU load word 0x100 (RAM=44 33 22 11) and fetch -> LSU served first with data_to_lsu=0x11223344. The fetch starts 2 cycles after the LSU ready pulse.
- Store half 0xBEEF to 0x201 -> two write cycles: (0x201,0xEF) then (0x202,0xBE). ready_to_lsu at E3.
- Store byte 0x41 to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays 0 during the stall, then one write. ready appears 5 cycles later than unstalled.
- rdy low for 3 cycles mid-fetch -> mem_wr=0 and no state change; the final line is still correct, ready delayed by 3.
- rst driven low mid-DWRITE -> all outputs 0 next cycle and state IDLE. No ready pulse follows.
